// File: rtl/cordic_angle_sequencer.sv
// CORDIC angle front-end and sequencer.
// Takes a signed Q16.16 angle and reduces it to [-pi, pi] in 2*pi steps. It folds the
// angle into [-pi/2, pi/2], starts the CORDIC core, and waits a fixed number of cycles.
// It then captures cos/sin, undoes the fold on cos, and holds the result until it is taken.
module cordic_angle_sequencer #(
  parameter int CORDIC_ITERATIONS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_theta,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_cos,
  output logic [31:0] out_sin,
  output logic        busy,
  output logic        cordic_init,
  output logic [31:0] cordic_theta,
  input  logic [31:0] cordic_cos,
  input  logic [31:0] cordic_sin
);

  // Q16.16 angle constants.
  localparam logic signed [31:0] PI       = 32'sd205887;
  localparam logic signed [31:0] NEG_PI   = -32'sd205887;
  localparam logic signed [31:0] HALF_PI  = 32'sd102944;
  localparam logic signed [31:0] NEG_HALF = -32'sd102944;
  localparam logic signed [31:0] TWO_PI   = 32'sd411775;

  // The wait counter runs 0..CORDIC_ITERATIONS+1. The capture happens on the last count.
  localparam int              CNT_W    = $clog2(CORDIC_ITERATIONS + 2) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CORDIC_ITERATIONS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REDUCE,
    S_FOLD,
    S_START,
    S_WAIT,
    S_DONE
  } state_t;

  state_t             state_reg;
  state_t             state_next;
  logic signed [31:0] t_reg;
  logic               neg_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [31:0]        theta_reg;
  logic [31:0]        cos_reg;
  logic [31:0]        sin_reg;

  logic               t_above;
  logic               t_below;

  assign t_above = (t_reg > PI);
  assign t_below = (t_reg < NEG_PI);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decode and Moore outputs.
  always_comb begin
    state_next  = state_reg;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    cordic_init = 1'b0;
    case (state_reg)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_next = S_REDUCE;
      end
      S_REDUCE: begin
        if (!t_above && !t_below) state_next = S_FOLD;
      end
      S_FOLD: begin
        state_next = S_START;
      end
      S_START: begin
        cordic_init = 1'b1;
        state_next  = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_reg == CNT_LAST) state_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        // A simultaneous in_valid is ignored here. The angle is taken in IDLE.
        if (out_ready) state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Angle reduction, fold, wait counting and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      t_reg     <= '0;
      neg_reg   <= 1'b0;
      cnt_reg   <= '0;
      theta_reg <= '0;
      cos_reg   <= '0;
      sin_reg   <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (in_valid) t_reg <= in_theta;
        end
        S_REDUCE: begin
          // One 2*pi step per cycle. Exactly +/-pi is already in range.
          if (t_above) begin
            t_reg <= t_reg - TWO_PI;
          end else if (t_below) begin
            t_reg <= t_reg + TWO_PI;
          end
        end
        S_FOLD: begin
          // Reflect about +/-pi/2. This keeps sin unchanged and negates cos.
          if (t_reg > HALF_PI) begin
            theta_reg <= PI - t_reg;
            neg_reg   <= 1'b1;
          end else if (t_reg < NEG_HALF) begin
            theta_reg <= NEG_PI - t_reg;
            neg_reg   <= 1'b1;
          end else begin
            theta_reg <= t_reg;
            neg_reg   <= 1'b0;
          end
        end
        S_START: begin
          cnt_reg <= '0;
        end
        S_WAIT: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_LAST) begin
            cos_reg <= neg_reg ? (32'd0 - cordic_cos) : cordic_cos;
            sin_reg <= cordic_sin;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign cordic_theta = theta_reg;
  assign out_cos      = cos_reg;
  assign out_sin      = sin_reg;

endmodule

// File: tb/tb_cordic_angle_sequencer.sv
// Self-checking bench for cordic_angle_sequencer with a behavioural CORDIC core stub.
module tb_cordic_angle_sequencer;

  localparam int N = 16;
  localparam longint PI_Q = 205887;
  localparam longint HP_Q = 102944;
  localparam longint TP_Q = 411775;
  localparam int TOL = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_theta = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_cos;
  logic [31:0] out_sin;
  logic        busy;
  logic        cordic_init;
  logic [31:0] cordic_theta;
  logic [31:0] cordic_cos = '0;
  logic [31:0] cordic_sin = '0;

  int    n_cmp = 0;
  int    n_bad = 0;
  string cur_name = "reset";

  cordic_angle_sequencer #(.CORDIC_ITERATIONS(N)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_theta(in_theta),
    .out_valid(out_valid), .out_ready(out_ready), .out_cos(out_cos), .out_sin(out_sin),
    .busy(busy), .cordic_init(cordic_init), .cordic_theta(cordic_theta),
    .cordic_cos(cordic_cos), .cordic_sin(cordic_sin)
  );

  always #5 clk = ~clk;

  function automatic longint q16(input real x);
    return longint'($rtoi(x * 65536.0 + ((x >= 0.0) ? 0.5 : -0.5)));
  endfunction

  // Core stub: junk while iterating, true result after N+1 edges, held afterwards.
  int          core_cnt = 0;
  bit          core_run = 1'b0;
  logic [31:0] core_theta = '0;
  always @(posedge clk) begin
    if (cordic_init) begin
      core_theta <= cordic_theta;
      core_cnt   <= 0;
      core_run   <= 1'b1;
      cordic_cos <= $urandom;
      cordic_sin <= $urandom;
    end else if (core_run) begin
      if (core_cnt == N) begin
        cordic_cos <= 32'(q16($cos($itor($signed(core_theta)) / 65536.0)));
        cordic_sin <= 32'(q16($sin($itor($signed(core_theta)) / 65536.0)));
        core_run   <= 1'b0;
      end else begin
        core_cnt   <= core_cnt + 1;
        cordic_cos <= $urandom;
        cordic_sin <= $urandom;
      end
    end
  end

  task automatic check(input bit ok, input string tag, input longint obs, input longint exp);
    n_cmp++;
    assert (ok === 1'b1) else begin
      n_bad++;
      $error("FAIL %s/%s observed=%0d expected=%0d", cur_name, tag, obs, exp);
    end
  endtask

  // Reference: closed-form count of 2*pi steps, fold by quadrant, real-valued cos/sin.
  task automatic model(input longint th, output longint k, output longint fold,
                       output longint ec, output longint es);
    longint red;
    if (th > PI_Q) begin
      k   = (th - PI_Q + TP_Q - 1) / TP_Q;
      red = th - k * TP_Q;
    end else if (th < -PI_Q) begin
      k   = (-PI_Q - th + TP_Q - 1) / TP_Q;
      red = th + k * TP_Q;
    end else begin
      k   = 0;
      red = th;
    end
    if (red > HP_Q)       fold = PI_Q - red;
    else if (red < -HP_Q) fold = -PI_Q - red;
    else                  fold = red;
    ec = q16($cos($itor(red) / 65536.0));
    es = q16($sin($itor(red) / 65536.0));
  endtask

  task automatic run_txn(input logic signed [31:0] th, input int hold, input string name);
    longint k, fold, ec, es, oc, os;
    int lat = 0;
    int inits = 0;
    bit dbl = 0, prev_init = 0, rdy_seen = 0, idle_seen = 0, done_seen = 0;
    logic [31:0] theta_init = '0, cos0, sin0;
    cur_name = name;
    model(longint'(th), k, fold, ec, es);
    @(negedge clk);
    check(in_ready === 1'b1, "in_ready_idle", longint'(in_ready), 1);
    in_theta  = th;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      if (cordic_init === 1'b1) begin
        inits++;
        theta_init = cordic_theta;
        if (prev_init) dbl = 1;
        prev_init = 1;
      end else begin
        prev_init = 0;
      end
      if (out_valid === 1'b1) begin
        done_seen = 1;
        break;
      end
      if (in_ready !== 1'b0) rdy_seen = 1;
      if (busy !== 1'b1) idle_seen = 1;
      in_valid = 1'($urandom_range(0, 1));
      in_theta = $urandom;
      @(posedge clk);
      lat++;
    end
    check(done_seen, "out_valid_timeout", longint'(lat), longint'(N + 5) + k);
    if (!done_seen) begin
      in_valid = 1'b0;
      return;
    end
    oc = longint'($signed(out_cos));
    os = longint'($signed(out_sin));
    $display("txn %s theta=%0d k=%0d lat=%0d cos=%0d sin=%0d", name, th, k, lat, oc, os);
    check(lat == longint'(N + 5) + k, "latency", longint'(lat), longint'(N + 5) + k);
    check(inits == 1 && !dbl, "init_pulses", longint'(inits), 1);
    check(longint'($signed(theta_init)) == fold, "theta_at_init", longint'($signed(theta_init)), fold);
    check(longint'($signed(cordic_theta)) == fold, "theta_at_done", longint'($signed(cordic_theta)), fold);
    check(!rdy_seen && in_ready === 1'b0, "in_ready_low_busy", longint'(rdy_seen), 0);
    check(!idle_seen && busy === 1'b1, "busy_high", longint'(idle_seen), 0);
    check(oc >= ec - TOL && oc <= ec + TOL, "out_cos", oc, ec);
    check(os >= es - TOL && os <= es + TOL, "out_sin", os, es);
    cos0 = out_cos;
    sin0 = out_sin;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      in_theta = $urandom;
      check(out_valid === 1'b1 && in_ready === 1'b0, "hold_valid", longint'(out_valid), 1);
      check(out_cos === cos0 && out_sin === sin0, "hold_stable", longint'($signed(out_cos)), longint'($signed(cos0)));
    end
    // Handshake with in_valid also high: only the output side may complete.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check(out_valid === 1'b0, "out_valid_drop", longint'(out_valid), 0);
    check(in_ready === 1'b1 && busy === 1'b0, "back_to_idle", longint'(in_ready), 1);
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check(in_ready === 1'b1, "rst_in_ready", longint'(in_ready), 1);
    check(out_valid === 1'b0 && busy === 1'b0, "rst_valid_busy", longint'(out_valid), 0);
    check(cordic_init === 1'b0, "rst_init", longint'(cordic_init), 0);
    check(cordic_theta === 32'd0, "rst_theta", longint'(cordic_theta), 0);
    check(out_cos === 32'd0 && out_sin === 32'd0, "rst_outs", longint'(out_cos), 0);
    rst = 1'b0;

    run_txn(32'sd0,       0, "T1_zero");
    run_txn(32'sd205887,  1, "T2_pi");
    run_txn(32'sd458752,  0, "T3_7rad");
    run_txn(-32'sd154416, 0, "T4_m3pi4");
    run_txn(32'sd300000,  5, "T5_hold");
    run_txn(32'sd102944,  0, "B_half_pi");
    run_txn(-32'sd102944, 0, "B_m_half_pi");
    run_txn(32'sd102945,  0, "B_above_half");
    run_txn(-32'sd205887, 0, "B_m_pi");
    run_txn(32'sd205888,  0, "B_above_pi");
    run_txn(-32'sd205888, 0, "B_below_m_pi");
    run_txn(32'sh7FFFFFFF, 0, "B_max");
    run_txn(32'sh80000000, 0, "B_min");

    // T6: reset while waiting on the core.
    cur_name = "T6_reset";
    @(negedge clk);
    in_theta = 32'sd0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    check(busy === 1'b1 && out_valid === 1'b0, "mid_busy", longint'(busy), 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check(in_ready === 1'b1 && busy === 1'b0, "abort_idle", longint'(in_ready), 1);
    check(out_valid === 1'b0 && cordic_theta === 32'd0, "abort_outs", longint'(out_valid), 0);
    run_txn(32'sd0, 0, "T6_after");

    for (int i = 0; i < 20; i++) begin
      logic signed [31:0] th;
      th = $signed(32'($urandom_range(0, 32'd8388608))) - 32'sd4194304;
      run_txn(th, int'($urandom_range(0, 3)), $sformatf("R%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
